// File: rtl/spi_emu_pkg.sv
// rtl/spi_emu_pkg.sv - shared encodings for the SPI sensor emulator
package spi_emu_pkg;

    typedef enum logic [1:0] {
        PAT_COUNTER = 2'b00,
        PAT_LFSR    = 2'b01,
        PAT_FIXED   = 2'b10,
        PAT_ECHO    = 2'b11
    } pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Right-shift Galois taps for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/spi_emu_sync_edge.sv
// rtl/spi_emu_sync_edge.sv - 2-FF synchroniser with rise/fall pulses
module spi_emu_sync_edge #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;
    logic [W-1:0] hist_q, hist_d;

    // Two metastability stages, then one history stage for edge detection
    always_comb begin
        s1_d   = din;
        s2_d   = s1_q;
        hist_d = s2_q;
    end

    // Synchroniser registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            hist_q <= RST_VAL;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
        end
    end

    assign dout = s2_q;
    assign rise = s2_q & ~hist_q;
    assign fall = ~s2_q & hist_q;

endmodule

// File: rtl/spi_sensor_emulator.sv
// rtl/spi_sensor_emulator.sv - SPI slave emulating a multichannel sensor
module spi_sensor_emulator
    import spi_emu_pkg::*;
#(
    parameter int                WORD_W     = 32,
    parameter int                NUM_CH     = 4,
    parameter int                CPHA       = 1,
    parameter logic [WORD_W-1:0] FIXED_WORD = 32'hA5A5_5A5A,
    parameter logic [WORD_W-1:0] LFSR_SEED  = 32'hACE1_0001
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic              cs_n,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [WORD_W-1:0] cmd_word,
    output logic              cmd_valid,
    output logic [15:0]       frame_cnt,
    output logic              short_frame_err
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SC_W = WORD_W - CH_W;
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam logic [WORD_W-1:0] POLY = WORD_W'(LFSR_POLY);
    localparam logic [BC_W-1:0]   FULL = BC_W'(WORD_W);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(NUM_CH - 1);

    logic [2:0] pin_sync, pin_rise, pin_fall;
    logic       sync_unused;

    spi_emu_sync_edge #(.W(3), .RST_VAL(3'b100)) u_sync (
        .clk  (clk_sys),
        .rst  (rst),
        .din  ({cs_n, sclk, mosi}),
        .dout (pin_sync),
        .rise (pin_rise),
        .fall (pin_fall)
    );

    logic cs_rise, cs_fall, mosi_s, launch_edge, sample_edge;
    assign cs_rise     = pin_rise[2];
    assign cs_fall     = pin_fall[2];
    assign mosi_s      = pin_sync[0];
    assign launch_edge = (CPHA != 0) ? pin_rise[1] : pin_fall[1];
    assign sample_edge = (CPHA != 0) ? pin_fall[1] : pin_rise[1];
    assign sync_unused = &{pin_sync[2:1], pin_rise[0], pin_fall[0]};

    state_t            state_q, state_d;
    pattern_t          pat_q, pat_d;
    logic [WORD_W-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic [WORD_W-1:0] cmd_word_q, cmd_word_d;
    logic              cmd_valid_q, cmd_valid_d, short_q, short_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
    logic [SC_W-1:0]   sample_cnt_q, sample_cnt_d;
    logic [WORD_W-1:0] lfsr_q, lfsr_d;
    logic [WORD_W-1:0] tx_word, lfsr_next;

    // Word presented to the master for the frame being loaded
    always_comb begin
        tx_word   = FIXED_WORD;
        lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
        case (pattern_t'(pattern_sel))
            PAT_COUNTER: tx_word = {ch_idx_q, sample_cnt_q};
            PAT_LFSR:    tx_word = lfsr_q;
            PAT_FIXED:   tx_word = FIXED_WORD;
            PAT_ECHO:    tx_word = cmd_word_q;
            default:     tx_word = FIXED_WORD;
        endcase
    end

    // Frame FSM: next state, shift registers and frame bookkeeping
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        miso_oe_d    = miso_oe_q;
        cmd_word_d   = cmd_word_q;
        cmd_valid_d  = 1'b0;
        short_d      = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ch_idx_d     = ch_idx_q;
        sample_cnt_d = sample_cnt_q;
        lfsr_d       = lfsr_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall && enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                pat_d     = pattern_t'(pattern_sel);
                miso_oe_d = 1'b1;
                bit_cnt_d = '0;
                rx_sr_d   = '0;
                if (CPHA == 0) begin
                    miso_d  = tx_word[WORD_W-1];
                    tx_sr_d = tx_word << 1;
                end else begin
                    miso_d  = 1'b0;
                    tx_sr_d = tx_word;
                end
                state_d = cs_rise ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q != FULL) begin
                    if (launch_edge) begin
                        miso_d  = tx_sr_q[WORD_W-1];
                        tx_sr_d = tx_sr_q << 1;
                    end
                    if (sample_edge) begin
                        rx_sr_d   = {rx_sr_q[WORD_W-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (bit_cnt_d == FULL) miso_d = 1'b0;
                // A sample in the same cycle as CS rise is already in bit_cnt_d
                if (cs_rise) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bit_cnt_q == FULL) begin
                    cmd_word_d  = rx_sr_q;
                    cmd_valid_d = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (ch_idx_q == LAST_CH) begin
                        ch_idx_d     = '0;
                        sample_cnt_d = sample_cnt_q + 1'b1;
                    end else begin
                        ch_idx_d = ch_idx_q + 1'b1;
                    end
                    if (pat_q == PAT_LFSR) lfsr_d = lfsr_next;
                end else begin
                    short_d = 1'b1;
                end
                miso_oe_d = 1'b0;
                miso_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pat_q        <= PAT_COUNTER;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            cmd_word_q   <= '0;
            cmd_valid_q  <= 1'b0;
            short_q      <= 1'b0;
            frame_cnt_q  <= '0;
            ch_idx_q     <= '0;
            sample_cnt_q <= '0;
            lfsr_q       <= LFSR_SEED;
        end else begin
            state_q      <= state_d;
            pat_q        <= pat_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            miso_oe_q    <= miso_oe_d;
            cmd_word_q   <= cmd_word_d;
            cmd_valid_q  <= cmd_valid_d;
            short_q      <= short_d;
            frame_cnt_q  <= frame_cnt_d;
            ch_idx_q     <= ch_idx_d;
            sample_cnt_q <= sample_cnt_d;
            lfsr_q       <= lfsr_d;
        end
    end

    assign miso            = miso_q;
    assign miso_oe         = miso_oe_q;
    assign cmd_word        = cmd_word_q;
    assign cmd_valid       = cmd_valid_q;
    assign frame_cnt       = frame_cnt_q;
    assign short_frame_err = short_q;

endmodule

// File: tb/tb_spi_sensor_emulator.sv
// tb/tb_spi_sensor_emulator.sv - self-checking bench for spi_sensor_emulator
module tb_spi_sensor_emulator;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable0 = 1'b0, enable1 = 1'b0;
    logic [1:0]  pattern_sel0 = 2'b01, pattern_sel1 = 2'b00;
    logic        cs_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
    logic        miso0, miso1, miso_oe0, miso_oe1;
    logic [31:0] cmd_word0, cmd_word1;
    logic        cmd_valid0, cmd_valid1, short0, short1;
    logic [15:0] frame_cnt0, frame_cnt1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc [2];

    typedef struct {
        bit          full;
        logic [31:0] cmd;
        logic [15:0] fcnt;
    } ev_t;
    ev_t evq0 [$];
    ev_t evq1 [$];

    int unsigned m_ch [2];
    int unsigned m_sample [2];
    logic [31:0] m_lfsr [2];
    logic [31:0] m_cmd [2];
    logic [15:0] m_fcnt [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_sensor_emulator #(.CPHA(1)) u_dut1 (
        .clk_sys(clk), .rst(rst), .enable(enable1), .pattern_sel(pattern_sel1),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso1), .miso_oe(miso_oe1),
        .cmd_word(cmd_word1), .cmd_valid(cmd_valid1), .frame_cnt(frame_cnt1),
        .short_frame_err(short1)
    );

    spi_sensor_emulator #(.CPHA(0)) u_dut0 (
        .clk_sys(clk), .rst(rst), .enable(enable0), .pattern_sel(pattern_sel0),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso0), .miso_oe(miso_oe0),
        .cmd_word(cmd_word0), .cmd_valid(cmd_valid0), .frame_cnt(frame_cnt0),
        .short_frame_err(short0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Polynomial x^32+x^22+x^2+x+1, right-shifting Galois form
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        int exps [4] = '{32, 22, 2, 1};
        logic [31:0] mask = '0;
        foreach (exps[k]) mask |= 32'd1 << (exps[k] - 1);
        return (s >> 1) ^ (s[0] ? mask : 32'd0);
    endfunction

    function automatic logic [31:0] model_word(input int m, input int pat);
        case (pat)
            0:       return (m_ch[m] << 30) | (m_sample[m] & 32'h3FFF_FFFF);
            1:       return m_lfsr[m];
            2:       return 32'hA5A5_5A5A;
            default: return m_cmd[m];
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ch[m] = 0; m_sample[m] = 0; m_lfsr[m] = 32'hACE1_0001;
            m_cmd[m] = '0; m_fcnt[m] = '0;
        end
        evq0.delete();
        evq1.delete();
    endtask

    task automatic model_complete(input int m, input int n, input logic [63:0] mw, input int pat);
        ev_t e;
        if (n >= 32) begin
            m_cmd[m]  = mw[63:32];
            m_fcnt[m] = m_fcnt[m] + 16'd1;
            m_ch[m]   = (m_ch[m] + 1) % 4;
            if (m_ch[m] == 0) m_sample[m]++;
            if (pat == 1) m_lfsr[m] = lfsr_step(m_lfsr[m]);
            e.full = 1'b1;
        end else begin
            e.full = 1'b0;
        end
        e.cmd  = m_cmd[m];
        e.fcnt = m_fcnt[m];
        if (m == 0) evq0.push_back(e); else evq1.push_back(e);
    endtask

    task automatic mon(input int m, input logic v, input logic s, input logic [31:0] cw,
                       input logic [15:0] fc);
        ev_t e;
        int  qs;
        if (v || s) begin
            qs = (m == 0) ? evq0.size() : evq1.size();
            if (qs == 0) begin
                chk("spurious_pulse", {62'd0, v, s}, 64'd0);
            end else begin
                if (m == 0) e = evq0.pop_front(); else e = evq1.pop_front();
                chk("ev_cmd_valid", v, e.full);
                chk("ev_short_err", s, !e.full);
                chk("ev_cmd_word", cw, e.cmd);
                chk("ev_frame_cnt", fc, e.fcnt);
                chk("ev_latency", cyc - rise_cyc[m], 4);
            end
        end
    endtask

    // Scoreboard for completion pulses of both instances
    always @(negedge clk) begin
        mon(0, cmd_valid0, short0, cmd_word0, frame_cnt0);
        mon(1, cmd_valid1, short1, cmd_word1, frame_cnt1);
    end

    task automatic spi_bits(input int n, input logic [63:0] w, input int mode,
                            input bit lat, input logic lat_exp, output logic [63:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            if (mode == 1) begin
                sclk = 1'b1;
                mosi = w[63-i];
                if (lat && i == 0) begin
                    wait_cyc(2);
                    chk("miso_lat_pre", miso1, 1'b0);
                    wait_cyc(1);
                    chk("miso_lat_post", miso1, lat_exp);
                    wait_cyc(H - 3);
                end else begin
                    wait_cyc(H);
                end
                rx = {rx[62:0], miso1};
                sclk = 1'b0;
                wait_cyc(H);
            end else begin
                mosi = w[63-i];
                wait_cyc(H);
                rx = {rx[62:0], miso0};
                sclk = 1'b1;
                wait_cyc(H);
                sclk = 1'b0;
            end
        end
    endtask

    task automatic frame(input int m, input int n, input logic [63:0] mw, input bit lat,
                         input logic lat_exp, output logic [63:0] rx);
        logic [31:0] exp_w;
        logic [63:0] exp_rx;
        int          pat, qs;
        pat   = (m == 0) ? int'(pattern_sel0) : int'(pattern_sel1);
        exp_w = model_word(m, pat);
        cs_n  = 1'b0;
        wait_cyc(H);
        chk("oe_active", (m == 0) ? miso_oe0 : miso_oe1, 1'b1);
        spi_bits(n, mw, m, lat, lat_exp, rx);
        exp_rx = {exp_w, 32'h0} >> (64 - n);
        chk("miso_word", rx, exp_rx);
        wait_cyc(H);
        model_complete(m, n, mw, pat);
        cs_n = 1'b1;
        rise_cyc[m] = cyc;
        wait_cyc(12);
        chk("oe_idle", (m == 0) ? miso_oe0 : miso_oe1, 1'b0);
        qs = (m == 0) ? evq0.size() : evq1.size();
        chk("ev_timeout", qs, 0);
        evq0.delete();
        evq1.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rx;
        logic [31:0] lit [5];
        lit = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0001};
        model_reset();
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);
        chk("rst_miso", {miso1, miso0}, 2'b00);
        chk("rst_oe", {miso_oe1, miso_oe0}, 2'b00);
        chk("rst_cmd_word", {cmd_word1, cmd_word0}, 64'd0);
        chk("rst_pulses", {cmd_valid1, cmd_valid0, short1, short0}, 4'd0);
        chk("rst_frame_cnt", {frame_cnt1, frame_cnt0}, 32'd0);

        // CPHA=0 instance, LFSR pattern
        enable0 = 1'b1;
        frame(0, 32, {32'h0F0F_0F0F, 32'h0}, 0, 1'b0, rx);
        chk("lfsr_word0", rx, 64'hACE1_0001);
        frame(0, 32, {32'hF0F0_F0F0, 32'h0}, 0, 1'b0, rx);
        chk("lfsr_word1", rx, 64'hD650_8003);
        chk("cpha0_cmd", cmd_word0, 32'hF0F0_F0F0);
        enable0 = 1'b0;

        // Counter pattern across channel wrap
        enable1 = 1'b1;
        pattern_sel1 = 2'b00;
        for (int i = 0; i < 5; i++) begin
            frame(1, 32, {32'h1111_1111 * i, 32'h0}, 0, 1'b0, rx);
            chk("counter_word", rx, {32'h0, lit[i]});
        end
        chk("frame_cnt_5", frame_cnt1, 16'd5);

        // Echo of the previous command
        frame(1, 32, {32'hDEAD_BEEF, 32'h0}, 0, 1'b0, rx);
        chk("counter_word6", rx, 64'h4000_0001);
        chk("cmd_deadbeef", cmd_word1, 32'hDEAD_BEEF);
        pattern_sel1 = 2'b11;
        frame(1, 32, {32'h1234_5678, 32'h0}, 0, 1'b0, rx);
        chk("echo_word", rx, 64'hDEAD_BEEF);

        // Short frame leaves all counters alone
        pattern_sel1 = 2'b00;
        frame(1, 12, {32'hFFFF_FFFF, 32'h0}, 0, 1'b0, rx);
        chk("short_bits", rx, 64'hC00);
        chk("short_frame_cnt", frame_cnt1, 16'd7);
        chk("short_cmd_kept", cmd_word1, 32'h1234_5678);
        frame(1, 32, {32'h0000_0000, 32'h0}, 0, 1'b0, rx);
        chk("after_short_word", rx, 64'hC000_0001);

        // Fixed pattern with 8 extra SCLK cycles
        pattern_sel1 = 2'b10;
        frame(1, 40, {32'h8765_4321, 32'hFF00_0000}, 1, 1'b1, rx);
        chk("fixed_40", rx, 64'hA5_A55A_5A00);
        chk("fixed_frame_cnt", frame_cnt1, 16'd9);
        chk("fixed_cmd", cmd_word1, 32'h8765_4321);

        // Reset in the middle of a frame
        pattern_sel1 = 2'b00;
        cs_n = 1'b0;
        wait_cyc(H);
        spi_bits(16, 64'hFFFF_0000_0000_0000, 1, 0, 1'b0, rx);
        chk("midframe_oe", miso_oe1, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_oe", miso_oe1, 1'b0);
        chk("async_rst_cnt", frame_cnt1, 16'd0);
        cs_n = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        model_reset();
        wait_cyc(4);
        frame(1, 32, {32'hCAFE_F00D, 32'h0}, 0, 1'b0, rx);
        chk("post_rst_word", rx, 64'h0);
        chk("post_rst_cnt", frame_cnt1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_sensor_emulator.md
Name: spi_sensor_emulator

Overview:
- Synthesizable, parametrised SPI slave that emulates an RHS2116-class multichannel sensor.
- Drives MISO with tagged sample words and captures MOSI command words.
- Used as the sensor stand-in for system benches and for on-board loopback bring-up against the SPI master / coax link.
- Oversamples CS_N, SCLK and MOSI on the system clock; supports selectable SPI phase, data patterns and detection of short frames.

Parameters:
- WORD_W, 32: bits per SPI transfer.
- NUM_CH, 4: emulated channel count (≥1); the channel index occupies the top CH_W = max(1, clog2(NUM_CH)) bits of each word.
- CPHA, 1: 1 = slave launches on SCLK rise and samples on SCLK fall; 0 = slave launches on SCLK fall and samples on SCLK rise. CPOL is fixed at 0.
- FIXED_WORD, 32'hA5A5_5A5A: word returned in fixed-pattern mode.
- LFSR_SEED, 32'hACE1_0001: nonzero LFSR reset value.

Ports:
- clk_sys  in  1  system clock; must be at least 8× the SCLK frequency.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, CS_N is ignored and MISO is held at 0.
- pattern_sel  in  2  00 counter, 01 LFSR, 10 fixed, 11 echo of last command. Sampled only at frame load.
- cs_n  in  1  SPI chip select, asynchronous to clk_sys.
- sclk  in  1  SPI clock, asynchronous to clk_sys.
- mosi  in  1  SPI data from master.
- miso  out  1  SPI data to master.
- miso_oe  out  1  high while a frame is active.
- cmd_word  out  WORD_W  last complete MOSI word.
- cmd_valid  out  1  one-cycle pulse when cmd_word updates.
- frame_cnt  out  16  completed-frame count; wraps at 0xFFFF→0.
- short_frame_err  out  1  one-cycle pulse when CS_N rises with fewer than WORD_W sampled bits.

Behaviour:
- Synchronisers: 2-FF synchronisers on cs_n, sclk and mosi, plus one history register per signal for edge detection. Synchronisers reset to cs_n=1, sclk=0, mosi=0.
- Reset values: miso=0, miso_oe=0, cmd_word=0, cmd_valid=0, frame_cnt=0, short_frame_err=0, channel index=0, sample counter=0, LFSR=LFSR_SEED, FSM=IDLE.
- FSM IDLE:
  - On a synced CS_N fall with enable=1, go to LOAD.
  - A CS_N fall with enable=0 is ignored until the next fall.
- FSM LOAD (1 cycle):
  - Build tx_word from pattern_sel:
    - counter: {ch_idx, sample_cnt[WORD_W-CH_W-1:0]}
    - LFSR: current LFSR state
    - fixed: FIXED_WORD
    - echo: cmd_word
  - Set miso_oe=1 and bit_cnt=0.
  - If CPHA=0, drive miso = tx_word MSB now; otherwise hold miso until the first launch edge.
  - Go to SHIFT.
- FSM SHIFT:
  - Launch edge (synced): miso ← next bit, MSB first.
  - Sample edge (synced): shift mosi into rx_sr; bit_cnt++.
  - Once bit_cnt = WORD_W, further SCLK edges are ignored and miso = 0.
  - Synced CS_N rise → DONE.
- FSM DONE (1 cycle):
  - bit_cnt = WORD_W:
    - cmd_word ← rx_sr; cmd_valid=1; frame_cnt++.
    - Advance ch_idx; at NUM_CH-1 it wraps to 0 and sample_cnt++ (sample_cnt wraps naturally).
    - In LFSR mode, step the LFSR once (Galois polynomial x^32+x^22+x^2+x+1, truncated to WORD_W).
  - bit_cnt < WORD_W:
    - short_frame_err=1.
    - No counter, channel, LFSR or cmd_word update.
  - Set miso_oe=0 and miso=0, then go to IDLE.
- Latency:
  - Pin edge to miso change: 3 clk_sys cycles.
  - CS_N rise to cmd_valid: 4 cycles.
- Enable deasserted mid-frame: the current frame completes normally; the block returns to IDLE afterwards.
- CS_N rise and sample edge detected in the same cycle: the sample is counted first, then the frame is closed.
- Async rst mid-frame: everything returns to reset values immediately. The first frame after reset uses ch 0, sample 0.

Decomposition:
- Package spi_emu_pkg: pattern_sel encodings, FSM state enum, LFSR polynomial constant.
- One sub-module, spi_emu_sync_edge: parametrised-width 2-FF synchroniser with rise/fall pulse outputs. It is instantiated once for {cs_n, sclk, mosi}.

Test Plan:
- Reset, enable=1, pattern 00, NUM_CH=4, CPHA=1, then 5 × 32-bit frames → master reads 0x00000000, 0x40000000, 0x80000000, 0xC0000000, 0x00000001; frame_cnt=5.
- Master sends MOSI 0xDEADBEEF, then pattern 11 on the next frame → cmd_valid pulse with cmd_word=0xDEADBEEF; next MISO word = 0xDEADBEEF.
- CS_N raised after 12 SCLK cycles → short_frame_err pulse; frame_cnt unchanged; next full frame repeats the same tag/count.
- Pattern 10 with 40 SCLK cycles in one frame → first 32 bits = 0xA5A55A5A, last 8 bits = 0; frame_cnt+1.
- CPHA=0 build, pattern 01 → first word = 0xACE10001, second word = LFSR step of the seed (checked against the bench model).
- rst pulsed after 16 bits of a frame → miso_oe=0 immediately; the next frame returns 0x00000000 and frame_cnt restarts from 0.
